// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: Kogge-Stone parallel-prefix carry-propagate adder.
// It adds the two reduced rows of the compressor tree. Registers sit between
// prefix levels at a configurable spacing, and a valid/ready stream handshake
// with a global stall controls the pipeline.
// Optional feature macro: PPA_GROUP_GP_EN adds the registered group
// generate/propagate outputs grp_g and grp_p, which are used to chain blocks
// into wider adders.
module pipelined_prefix_adder #(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PPA_GROUP_GP_EN
    ,
    output logic             grp_g,
    output logic             grp_p
`endif
);

    localparam int LVL = $clog2(WIDTH);

    // A global stall: the whole pipe moves only when the output slot is free or drained.
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // ---- stage 0: operand capture ----
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             vld_p0;

    // Operand valid bit; this is the only control state that reset clears in this stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (advance) begin
            vld_p0 <= in_valid;
        end
    end

    // Operand data registers hold their value on a stall and are never reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            a_p0 <= a;
            b_p0 <= b;
        end
    end

    // ---- prefix levels: level k combines spans of 2^k ----
    for (genvar k = 0; k < LVL; k++) begin : lvl
        localparam int SPAN = 1 << k;

        logic [WIDTH-1:0] g_in;
        logic [WIDTH-1:0] p_in;
        logic [WIDTH-1:0] po_in;
        logic             v_in;
        logic [WIDTH-1:0] g_nx;
        logic [WIDTH-1:0] p_nx;
        logic [WIDTH-1:0] g_out;
        logic [WIDTH-1:0] p_out;
        logic [WIDTH-1:0] po_out;
        logic             v_out;

        if (k == 0) begin : src
            assign g_in  = a_p0 & b_p0;
            assign p_in  = a_p0 ^ b_p0;
            assign po_in = a_p0 ^ b_p0;
            assign v_in  = vld_p0;
        end else begin : src
            assign g_in  = lvl[k-1].g_out;
            assign p_in  = lvl[k-1].p_out;
            assign po_in = lvl[k-1].po_out;
            assign v_in  = lvl[k-1].v_out;
        end

        // Black-cell combine for every bit that has a partner 2^k positions below it.
        always_comb begin
            g_nx = g_in;
            p_nx = p_in;
            for (int i = SPAN; i < WIDTH; i++) begin
                g_nx[i] = g_in[i] | (p_in[i] & g_in[i-SPAN]);
                p_nx[i] = p_in[i] & p_in[i-SPAN];
            end
        end

        if ((k > 0) && (k % PIPE_EVERY == 0)) begin : reg_stage
            // ---- pipeline register after this prefix level ----
            // Valid bit for this segment; reset discards in-flight operand pairs.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_out <= 1'b0;
                end else if (advance) begin
                    v_out <= v_in;
                end
            end

            // Segment data is carried forward; the raw propagate travels along for the sum.
            always_ff @(posedge clk) begin
                if (advance) begin
                    g_out  <= g_nx;
                    p_out  <= p_nx;
                    po_out <= po_in;
                end
            end
        end else begin : comb_stage
            assign g_out  = g_nx;
            assign p_out  = p_nx;
            assign po_out = po_in;
            assign v_out  = v_in;
        end
    end

    // ---- output stage: sum formation and result register ----
    logic [WIDTH-1:0] g_fin;
    logic [WIDTH-1:0] sum_nx;
    logic             unused_p;

    assign g_fin    = lvl[LVL-1].g_out;
    assign sum_nx   = lvl[LVL-1].po_out ^ {g_fin[WIDTH-2:0], 1'b0};
    assign unused_p = ^lvl[LVL-1].p_out;

    // Result register: reset clears it, and it holds steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (advance) begin
            out_valid <= lvl[LVL-1].v_out;
            sum       <= sum_nx;
            cout      <= g_fin[WIDTH-1];
        end
    end

`ifdef PPA_GROUP_GP_EN
    // Group generate/propagate over the full word, registered alongside sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_g <= 1'b0;
            grp_p <= 1'b0;
        end else if (advance) begin
            grp_g <= g_fin[WIDTH-1];
            grp_p <= lvl[LVL-1].p_out[WIDTH-1];
        end
    end
`endif

endmodule
